// File: rtl/fifo_rd_pkg.sv
// Shared defaults and types for the FIFO read-side master.
// Optional statistics counters are enabled with FIFO_RD_CTRL_STATS_EN.
package fifo_rd_pkg;

  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned BUF_DEPTH_DEF = 4;

  typedef logic [DATA_W_DEF-1:0] data_t;

  localparam int unsigned XFER_CNT_W  = 32;
  localparam int unsigned STALL_CNT_W = 16;

endpackage

// File: rtl/fifo_rd_buf.sv
// Circular output buffer for fifo_rd_ctrl: wrap-around pointers, occupancy count,
// and zeroed read data whenever the buffer is empty.
module fifo_rd_buf
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = BUF_DEPTH_DEF,
  localparam int unsigned PtrW  = $clog2(DEPTH),
  localparam int unsigned OccW  = PtrW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] pop_data_o,
  output logic [OccW-1:0]   count_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [OccW-1:0]   occ_q, occ_d;

  always_comb begin
    occ_d = occ_q;
    case ({push_i, pop_i})
      2'b10:   occ_d = occ_q + OccW'(1);
      2'b01:   occ_d = occ_q - OccW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      occ_q <= occ_d;
    end
  end

  // Storage carries no reset; the read port is gated by occupancy instead.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = (occ_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o    = occ_q;

  // The credit check upstream makes a capture into a full buffer impossible.
  push_into_full_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && (occ_q == OccW'(DEPTH))));

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side master: pops the synchronous FIFO under credit control and streams words out.
// Defining FIFO_RD_CTRL_STATS_EN adds transfer and stall counters.
module fifo_rd_ctrl
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned BUF_DEPTH = BUF_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              busy
`ifdef FIFO_RD_CTRL_STATS_EN
  ,
  output logic [XFER_CNT_W-1:0]  xfer_cnt,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  localparam int unsigned OccW    = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned CreditW = OccW + 1;

  logic               active_q;
  logic               inflight_q;
  logic [OccW-1:0]    occ;
  logic [CreditW-1:0] credit;
  logic               xfer;

  // Words already buffered plus the one still on its way from the FIFO.
  assign credit  = {1'b0, occ} + CreditW'(inflight_q);
  assign fifo_rd = active_q & en & ~fifo_empty & (credit < CreditW'(BUF_DEPTH));

  assign m_valid = (occ != '0);
  assign xfer    = m_valid & m_ready;
  assign busy    = m_valid | inflight_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q   <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      active_q   <= 1'b1;
      inflight_q <= fifo_rd;
    end
  end

  fifo_rd_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (inflight_q),
    .push_data_i (fifo_dout),
    .pop_i       (xfer),
    .pop_data_o  (m_data),
    .count_o     (occ)
  );

`ifdef FIFO_RD_CTRL_STATS_EN
  logic [XFER_CNT_W-1:0]  xfer_cnt_q;
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (xfer) xfer_cnt_q <= xfer_cnt_q + XFER_CNT_W'(1);
      if (m_valid && !m_ready && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
      end
    end
  end

  assign xfer_cnt  = xfer_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: queue-based FIFO and stream reference model,
// directed scenarios followed by a randomized traffic phase.
module tb_fifo_rd_ctrl;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       fifo_empty = 1'b1;
  logic       fifo_rd;
  logic [7:0] fifo_dout = 8'h00;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready = 1'b0;
  logic       busy;
`ifdef FIFO_RD_CTRL_STATS_EN
  logic [31:0] xfer_cnt;
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  fifo_rd_ctrl #(
    .DATA_W    (8),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .fifo_dout  (fifo_dout),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .busy       (busy)
`ifdef FIFO_RD_CTRL_STATS_EN
    ,
    .xfer_cnt   (xfer_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference state: FIFO contents, words held for the stream, word on its way.
  logic [7:0] fifo_q [$];
  logic [7:0] buf_q  [$];
  logic [7:0] got_q  [$];
  logic [7:0] sent_q [$];
  logic       act_m = 1'b0;
  logic       infl_m = 1'b0;
  logic [7:0] infl_word = 8'h00;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  int cyc = 0;
  int rd_cnt, rd_run, max_rd_run, x_run, max_x_run, first_rd, first_mv, stall_obs;

  task automatic clear_obs();
    rd_cnt = 0; rd_run = 0; max_rd_run = 0; x_run = 0; max_x_run = 0;
    first_rd = -1; first_mv = -1; stall_obs = 0;
    got_q.delete();
  endtask

  task automatic push_word(input logic [7:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock: called just after a rising edge, checks at the falling edge.
  task automatic cycle();
    logic       exp_rd, exp_valid, exp_busy, xfer_m, dut_rd;
    logic [7:0] exp_data;
    #4;
    exp_valid = (buf_q.size() != 0);
    exp_data  = exp_valid ? buf_q[0] : 8'h00;
    exp_busy  = exp_valid | infl_m;
    exp_rd    = rst_n && act_m && en && (fifo_q.size() != 0) &&
                ((buf_q.size() + int'(infl_m)) < DEPTH);
    check_eq("fifo_rd", 32'(fifo_rd), 32'(exp_rd));
    check_eq("m_valid", 32'(m_valid), 32'(exp_valid));
    check_eq("m_data",  32'(m_data),  32'(exp_data));
    check_eq("busy",    32'(busy),    32'(exp_busy));
    if (prev_stall) check_eq("m_data_hold", 32'(m_data), 32'(prev_data));
    xfer_m = exp_valid && m_ready;
    dut_rd = fifo_rd;
    if (fifo_rd) begin
      rd_cnt++; rd_run++;
      if (rd_run > max_rd_run) max_rd_run = rd_run;
      if (first_rd < 0) first_rd = cyc;
    end else rd_run = 0;
    if (m_valid && m_ready) begin
      got_q.push_back(m_data);
      x_run++;
      if (x_run > max_x_run) max_x_run = x_run;
    end else x_run = 0;
    if (m_valid && first_mv < 0) first_mv = cyc;
    if (m_valid && !m_ready) stall_obs++;
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (xfer_m) void'(buf_q.pop_front());
      if (infl_m) buf_q.push_back(infl_word);
      infl_m = exp_rd;
      if (exp_rd) infl_word = fifo_q[0];
      if (dut_rd && fifo_q.size() != 0) fifo_dout = fifo_q.pop_front();
      act_m = 1'b1;
    end
    fifo_empty = (fifo_q.size() == 0);
    cyc++;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_fifo_rd", 32'(fifo_rd), 32'h0);
    check_eq("rst_m_valid", 32'(m_valid), 32'h0);
    check_eq("rst_m_data",  32'(m_data),  32'h0);
    check_eq("rst_busy",    32'(busy),    32'h0);
    buf_q.delete();
    infl_m = 1'b0; act_m = 1'b0; prev_stall = 1'b0;
  endtask

  // Run until the controller is idle (at least min_cyc cycles, at most max_cyc).
  task automatic drain(input string tag, input int min_cyc, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (i >= min_cyc && !busy && (!en || fifo_q.size() == 0)) break;
      cycle();
    end
    check_eq(tag, 32'(busy), 32'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rel_cyc;
    clear_obs();
    @(posedge clk);
    #1;
    apply_reset();
    // Reset release with three words waiting.
    cycle();
    cycle();
    push_word(8'hA1); push_word(8'hA2); push_word(8'hA3);
    en = 1'b1; m_ready = 1'b1;
    rst_n = 1'b1;
    rel_cyc = cyc;
    drain("t1_idle", 4, 40);
    check_eq("t1_first_rd", 32'(first_rd - rel_cyc), 32'd1);
    check_eq("t1_latency",  32'(first_mv - first_rd), 32'd2);
    check_eq("t1_count", 32'(got_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < got_q.size(); i++) check_eq("t1_word", 32'(got_q[i]), 32'hA1 + i);

    // Eight-word burst at full throughput.
    clear_obs();
    for (int i = 0; i < 8; i++) push_word(8'(8'h11 + i));
    drain("t2_idle", 12, 40);
    check_eq("t2_rd_run",   32'(max_rd_run), 32'd8);
    check_eq("t2_xfer_run", 32'(max_x_run),  32'd8);
    check_eq("t2_count", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) check_eq("t2_word", 32'(got_q[i]), 32'h11 + i);

    // Back-pressure: credits stop reads at buffer depth.
    clear_obs();
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) push_word(8'(8'h20 + i));
    for (int i = 0; i < 12; i++) cycle();
    check_eq("t3_reads",  32'(rd_cnt),  32'd4);
    check_eq("t3_rd_low", 32'(fifo_rd), 32'h0);
    check_eq("t3_head",   32'(m_data),  32'h20);
    m_ready = 1'b1;
    drain("t3_idle", 4, 60);
    check_eq("t3_count", 32'(got_q.size()), 32'd10);
    for (int i = 0; i < 10 && i < got_q.size(); i++) check_eq("t3_word", 32'(got_q[i]), 32'h20 + i);

    // en dropped right after a read issue.
    clear_obs();
    for (int i = 0; i < 6; i++) push_word(8'(8'h30 + i));
    for (int i = 0; i < 10 && rd_cnt == 0; i++) cycle();
    en = 1'b0;
    drain("t4_idle", 4, 40);
    check_eq("t4_reads", 32'(rd_cnt), 32'd1);
    check_eq("t4_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() != 0) check_eq("t4_word", 32'(got_q[0]), 32'h30);
    check_eq("t4_fifo_left", 32'(fifo_q.size()), 32'd5);
    en = 1'b1;
    drain("t4_flush", 4, 40);

    // Reset mid-operation with three buffered words.
    clear_obs();
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(8'(8'h40 + i));
    for (int i = 0; i < 10 && rd_cnt < 3; i++) cycle();
    en = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    check_eq("t5_occ3", 32'(buf_q.size()), 32'd3);
    apply_reset();
    cycle();
    cycle();
    clear_obs();
    rst_n = 1'b1; en = 1'b1; m_ready = 1'b1;
    drain("t5_idle", 4, 40);
    check_eq("t5_count", 32'(got_q.size()), 32'd5);
    if (got_q.size() != 0) check_eq("t5_resume", 32'(got_q[0]), 32'h43);

    // Randomized traffic against the reference model.
    clear_obs();
    sent_q.delete();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(2) == 0 && fifo_q.size() < 20) begin
        logic [7:0] w;
        w = 8'($urandom);
        sent_q.push_back(w);
        push_word(w);
      end
      en      = ($urandom_range(4) != 0);
      m_ready = ($urandom_range(3) != 0);
      cycle();
    end
    en = 1'b1; m_ready = 1'b1;
    drain("rand_idle", 4, 200);
    check_eq("rand_count", 32'(got_q.size()), 32'(sent_q.size()));
    for (int i = 0; i < sent_q.size() && i < got_q.size(); i++) begin
      check_eq("rand_word", 32'(got_q[i]), 32'(sent_q[i]));
    end

`ifdef FIFO_RD_CTRL_STATS_EN
    apply_reset();
    cycle();
    check_eq("stats_rst_xfer",  xfer_cnt, 32'd0);
    check_eq("stats_rst_stall", 32'(stall_cnt), 32'd0);
    clear_obs();
    rst_n = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(8'(8'h50 + i));
    for (int i = 0; i < 30 && stall_obs < 7; i++) cycle();
    m_ready = 1'b1;
    drain("stats_idle", 4, 40);
    check_eq("stats_xfer",  xfer_cnt, 32'd5);
    check_eq("stats_stall", 32'(stall_cnt), 32'd7);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
